// File: rtl/multi_ro_arb.sv
// multi_ro_arb: round-robin readout of NCH FWFT channel FIFOs into one framed output stream.
// Build option MULTI_RO_TRAILER_EN appends a trailer word carrying the payload count to each packet.
module multi_ro_arb #(
    parameter int NCH      = 4,
    parameter int DW       = 16,
    parameter int MAXBURST = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NCH-1:0]         DAVAIL,
    input  logic [NCH*DW-1:0]      CH_DATA,
    output logic [NCH-1:0]         CH_RD,
    input  logic                   OUT_FULL,
    output logic [DW-1:0]          OUT_DATA,
    output logic                   OUT_WR,
    output logic [$clog2(NCH)-1:0] CHSEL,
    output logic                   BUSY
);
    localparam int CW = $clog2(NCH);
    localparam logic [7:0] MAXB = 8'(MAXBURST);

`ifdef MULTI_RO_TRAILER_EN
    typedef enum logic [2:0] {IDLE, ARB, HEADER, READOUT, TRAILER} state_t;
`else
    typedef enum logic [2:0] {IDLE, ARB, HEADER, READOUT} state_t;
`endif

    state_t          state_q;
    logic [CW-1:0]   ptr_q;
    logic [CW-1:0]   chsel_q;
    logic [7:0]      count_q;
    logic [DW-1:0]   out_data_q;
    logic            out_wr_q;

    logic [CW-1:0]   ptr_d;
    logic [CW-1:0]   grant_idx;
    logic            grant_vld;
    logic [CW-1:0]   cand;
    logic [DW-1:0]   sel_data;
    logic            rd_en;

    function automatic logic [DW-1:0] frame_word(input logic [3:0] tag, input logic [7:0] low);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1 -: 4] = tag;
        w[7:0] = low;
        return w;
    endfunction

    // Scan from the highest offset down so the nearest requester above PTR wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = CW'((int'(ptr_q) + i) % NCH);
            if (DAVAIL[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (chsel_q == CW'(k)) sel_data = CH_DATA[k*DW +: DW];
        end
    end

    assign ptr_d = (chsel_q == CW'(NCH - 1)) ? '0 : chsel_q + CW'(1);
    assign rd_en = (state_q == READOUT) && !RST && DAVAIL[chsel_q] && !OUT_FULL && (count_q < MAXB);

    assign CH_RD    = rd_en ? (NCH'(1) << chsel_q) : '0;
    assign OUT_DATA = out_data_q;
    assign OUT_WR   = out_wr_q;
    assign CHSEL    = chsel_q;
    assign BUSY     = (state_q != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            chsel_q    <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
        end else begin
            out_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|DAVAIL) state_q <= ARB;
                end
                ARB: begin
                    if (grant_vld) begin
                        chsel_q <= grant_idx;
                        state_q <= HEADER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HEADER: begin
                    if (!OUT_FULL) begin
                        out_data_q <= frame_word(4'hA, 8'(chsel_q));
                        out_wr_q   <= 1'b1;
                        count_q    <= '0;
                        state_q    <= READOUT;
                    end
                end
                READOUT: begin
                    if (rd_en) begin
                        out_data_q <= sel_data;
                        out_wr_q   <= 1'b1;
                        count_q    <= count_q + 8'd1;
                    end else if (!OUT_FULL) begin
                        // Not reading with space available: channel drained or burst limit hit.
                        ptr_q <= ptr_d;
`ifdef MULTI_RO_TRAILER_EN
                        state_q <= TRAILER;
`else
                        state_q <= IDLE;
`endif
                    end
                end
`ifdef MULTI_RO_TRAILER_EN
                TRAILER: begin
                    if (!OUT_FULL) begin
                        out_data_q <= frame_word(4'hE, count_q);
                        out_wr_q   <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_ro_arb.sv
// Self-checking bench for multi_ro_arb: FWFT channel FIFO models, table-driven and random
// packet scenarios compared against a packet-level stream model, plus hand-written corner cases.
module tb_multi_ro_arb;
    localparam int NCH  = 4;
    localparam int DW   = 16;
    localparam int MAXB = 4;
`ifdef MULTI_RO_TRAILER_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NCH-1:0]    DAVAIL = '0;
    logic [NCH*DW-1:0] CH_DATA = '0;
    logic [NCH-1:0]    CH_RD;
    logic              OUT_FULL = 1'b0;
    logic [DW-1:0]     OUT_DATA;
    logic              OUT_WR;
    logic [1:0]        CHSEL;
    logic              BUSY;

    always #5 CLK = ~CLK;

    multi_ro_arb #(.NCH(NCH), .DW(DW), .MAXBURST(MAXB)) dut (
        .CLK(CLK), .RST(RST), .DAVAIL(DAVAIL), .CH_DATA(CH_DATA), .CH_RD(CH_RD),
        .OUT_FULL(OUT_FULL), .OUT_DATA(OUT_DATA), .OUT_WR(OUT_WR), .CHSEL(CHSEL), .BUSY(BUSY)
    );

    typedef struct packed {
        logic [3:0][3:0] nw;     // words preloaded per channel, nibble k = channel k
        logic [7:0]      fp;     // percent of cycles with OUT_FULL raised
        logic [7:0]      pkts;   // expected packet count
        logic [7:0]      words;  // expected payload word count
    } vec_t;

    logic [DW-1:0] chq [NCH][$];
    logic [DW-1:0] outlog[$];
    logic [DW-1:0] explog[$];
    logic [NCH-1:0] mask = '0;
    int checks = 0;
    int errors = 0;
    int proto_err = 0;
    int full_pct = 0;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int k = 0; k < NCH; k++) begin
            DAVAIL[k] = (chq[k].size() > 0) && !mask[k];
            CH_DATA[k*DW +: DW] = (chq[k].size() > 0) ? chq[k][0] : '0;
        end
    endtask

    // One clock: sample the read strobe before the edge, pop FIFOs and log writes after it.
    task automatic tick();
        logic [NCH-1:0] rd;
        logic fprev;
        #1;
        rd = CH_RD;
        fprev = OUT_FULL;
        if (rd !== '0) begin
            if (rd != (4'b0001 << CHSEL) || OUT_FULL || ((rd & ~DAVAIL) != '0) || RST) proto_err++;
        end
        @(posedge CLK);
        #1;
        for (int k = 0; k < NCH; k++) if (rd[k]) void'(chq[k].pop_front());
        if (OUT_WR === 1'b1) begin
            outlog.push_back(OUT_DATA);
            if (fprev) proto_err++;
        end
        if (full_pct > 0) OUT_FULL = ($urandom_range(99) < full_pct);
        apply_inputs();
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NCH; k++) if (chq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        mask = '0;
        OUT_FULL = 1'b0;
        full_pct = 0;
        for (int k = 0; k < NCH; k++) chq[k].delete();
        apply_inputs();
        tick();
        tick();
        chk("rst_busy", BUSY, 0);
        chk("rst_wr", OUT_WR, 0);
        chk("rst_data", OUT_DATA, 0);
        chk("rst_chsel", CHSEL, 0);
        chk("rst_chrd", CH_RD, 0);
        RST = 1'b0;
        outlog.delete();
        proto_err = 0;
    endtask

    // Packet-level model: round robin from channel 0 over the preloaded FIFO contents.
    task automatic build_model();
        int pos[NCH];
        int ptr;
        int k;
        int n;
        explog.delete();
        ptr = 0;
        for (int c = 0; c < NCH; c++) pos[c] = 0;
        while (1) begin
            k = -1;
            for (int i = 0; i < NCH; i++)
                if (k < 0 && pos[(ptr + i) % NCH] < chq[(ptr + i) % NCH].size()) k = (ptr + i) % NCH;
            if (k < 0) break;
            n = chq[k].size() - pos[k];
            if (n > MAXB) n = MAXB;
            explog.push_back(16'hA000 | 16'(k));
            for (int j = 0; j < n; j++) explog.push_back(chq[k][pos[k] + j]);
            pos[k] += n;
            if (TRL != 0) explog.push_back(16'hE000 | 16'(n));
            ptr = (k + 1) % NCH;
        end
    endtask

    task automatic run_idle(input string nm, input int budget);
        int cyc;
        bit done;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
            if (BUSY === 1'b0 && all_empty()) done = 1'b1;
        end
        chk({nm, "_idle"}, done, 1);
    endtask

    task automatic wait_log(input string nm, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (outlog.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        chk({nm, "_reached"}, outlog.size(), n);
    endtask

    task automatic cmp_stream(input string nm);
        chk({nm, "_len"}, outlog.size(), explog.size());
        for (int i = 0; i < explog.size(); i++)
            chk($sformatf("%s_w%0d", nm, i), (i < outlog.size()) ? 32'(outlog[i]) : 32'hFFFF_FFFF, 32'(explog[i]));
        chk({nm, "_proto"}, proto_err, 0);
        proto_err = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{nw: 16'h0300, fp: 8'd0,  pkts: 8'd1, words: 8'd3};
        tbl[1] = '{nw: 16'h8888, fp: 8'd0,  pkts: 8'd8, words: 8'd32};
        tbl[2] = '{nw: 16'h6001, fp: 8'd30, pkts: 8'd3, words: 8'd7};
        tbl[3] = '{nw: 16'h0090, fp: 8'd40, pkts: 8'd3, words: 8'd9};
        tbl[4] = '{nw: 16'h1052, fp: 8'd25, pkts: 8'd4, words: 8'd8};

        do_reset();

        // Channel 2 with three known words.
        chq[2].push_back(16'h1111);
        chq[2].push_back(16'h2222);
        chq[2].push_back(16'h3333);
        apply_inputs();
        run_idle("ch2", 200);
        explog.delete();
        explog.push_back(16'hA002);
        explog.push_back(16'h1111);
        explog.push_back(16'h2222);
        explog.push_back(16'h3333);
        if (TRL != 0) explog.push_back(16'hE003);
        cmp_stream("ch2");
        chk("ch2_busy_end", BUSY, 0);

        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int k = 0; k < NCH; k++)
                for (int j = 0; j < int'(tbl[t].nw[k]); j++) chq[k].push_back(16'(($urandom & 32'h0FFF) | (k << 12)));
            full_pct = int'(tbl[t].fp);
            build_model();
            apply_inputs();
            run_idle($sformatf("tbl%0d", t), 3000);
            full_pct = 0;
            OUT_FULL = 1'b0;
            chk($sformatf("tbl%0d_writes", t), outlog.size(),
                int'(tbl[t].pkts) * (1 + TRL) + int'(tbl[t].words));
            cmp_stream($sformatf("tbl%0d", t));
        end

        // Five-cycle stall after the first payload word.
        do_reset();
        for (int j = 0; j < 4; j++) chq[0].push_back(16'h5000 + 16'(j));
        build_model();
        apply_inputs();
        wait_log("stall", 2, 50);
        OUT_FULL = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("stall_chrd%0d", s), CH_RD, 0);
            tick();
            chk($sformatf("stall_wr%0d", s), OUT_WR, 0);
        end
        OUT_FULL = 1'b0;
        run_idle("stall", 200);
        cmp_stream("stall");

        // Empty burst: channel 1 drops right after its header.
        do_reset();
        chq[1].push_back(16'h7777);
        apply_inputs();
        wait_log("empty", 1, 50);
        mask = 4'b0010;
        apply_inputs();
        for (int s = 0; s < 6; s++) tick();
        explog.delete();
        explog.push_back(16'hA001);
        if (TRL != 0) explog.push_back(16'hE000);
        cmp_stream("empty");
        chk("empty_busy", BUSY, 0);
        mask = '0;
        chq[2].push_back(16'h8888);
        outlog.delete();
        apply_inputs();
        run_idle("empty_ptr", 200);
        chk("empty_ptr_next", (outlog.size() > 0) ? 32'(outlog[0]) : 32'hFFFF_FFFF, 32'hA002);

        // Reset in the middle of a five-word burst.
        do_reset();
        chq[1].push_back(16'h1234);
        apply_inputs();
        run_idle("mid_pre", 200);
        outlog.delete();
        for (int j = 0; j < 5; j++) chq[2].push_back(16'h9000 + 16'(j));
        apply_inputs();
        wait_log("mid", 3, 50);
        RST = 1'b1;
        tick();
        chk("mid_rst_wr", OUT_WR, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_chsel", CHSEL, 0);
        RST = 1'b0;
        outlog.delete();
        chq[0].push_back(16'h4321);
        build_model();
        apply_inputs();
        run_idle("mid_post", 300);
        chk("mid_first_hdr", (outlog.size() > 0) ? 32'(outlog[0]) : 32'hFFFF_FFFF, 32'hA000);
        cmp_stream("mid_post");

        // Randomized loads and back-pressure.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int k = 0; k < NCH; k++) begin
                int n;
                n = $urandom_range(0, 9);
                for (int j = 0; j < n; j++) chq[k].push_back(16'($urandom));
            end
            full_pct = $urandom_range(0, 50);
            build_model();
            apply_inputs();
            run_idle($sformatf("rnd%0d", it), 3000);
            full_pct = 0;
            OUT_FULL = 1'b0;
            cmp_stream($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
